alu_mc_param: RTL and testbench
===============================

// Module: alu_mc_param
// PURPOSE
// - Parametrised, multi-cycle successor to the 16-bit registered ALU; same 16-op function map and flag set.
// - Adds: WIDTH generalisation, IN_VALID/IN_READY input handshake, OUT_VALID result strobe.
// - Adds: double-width MUL result (ALU_OUT_HI), iterative restoring DIV with remainder, variable shift amount.
// - Adds: Carry/Zero/DivZero status. Sits between operand register file and datapath writeback.
// PARAMETERS
// - WIDTH  16  operand/result width, >=4
// - SHW    $clog2(WIDTH)  shift-amount bits taken from B[SHW-1:0]
// PORTS
// - CLK           in   1      clock, all logic on rising edge
// - RST           in   1      synchronous reset, active-high
// - A             in   WIDTH  operand A
// - B             in   WIDTH  operand B
// - ALU_FUN       in   4      function select
// - IN_VALID      in   1      operands/function valid this cycle
// - IN_READY      out  1      block can accept; accept = IN_VALID & IN_READY
// - ALU_OUT       out  WIDTH  result (low half for MUL, quotient for DIV)
// - ALU_OUT_HI    out  WIDTH  MUL high half, DIV remainder, else 0
// - OUT_VALID     out  1      one-cycle strobe: ALU_OUT* and flags updated
// - Arith_flag / Logic_flag / CMP_flag / Shift_flag   out  1  class of last op (one-hot or all 0)
// - Carry_flag    out  1      ADD carry-out / SUB borrow; 0 for other ops
// - Zero_flag     out  1      ALU_OUT==0 (all classes incl. default)
// - DivZero_flag  out  1      last op was DIV with B==0
// BEHAVIOUR
// - Reset: state IDLE, IN_READY=1, OUT_VALID=0, ALU_OUT=0, ALU_OUT_HI=0, all flags 0 except Zero_flag=0.
// - Function map: 0 ADD, 1 SUB (A-B, mod 2^WIDTH), 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR,
//   9 XNOR, A EQ, B GT, C LT (unsigned), D SHR A>>B[SHW-1:0], E SHL A<<B[SHW-1:0], F default.
// - CMP: true -> EQ=1, GT=2, LT=3; false -> 0. Default: ALU_OUT=0, class flags all 0.
// - FSM IDLE/DIV. IDLE: IN_READY=1; accept of non-DIV op -> result registered on same edge,
//   OUT_VALID=1 next cycle (latency 1); back-to-back accepts give OUT_VALID every cycle.
// - DIV accept with B!=0 -> DIV state, IN_READY=0; one quotient bit per cycle, WIDTH cycles;
//   OUT_VALID and results on cycle WIDTH+1 after accept; IN_READY=1 in that same cycle (new accept allowed).
// - DIV with B==0: no DIV state, latency 1, ALU_OUT=all ones, ALU_OUT_HI=A, DivZero_flag=1, Arith_flag=1.
// - Operands for DIV captured at accept; A/B/ALU_FUN changes during DIV ignored.
// - IN_VALID while IN_READY=0: ignored, not queued; driver must hold until accepted.
// - Outputs and flags hold between OUT_VALID strobes; no output back-pressure.
// - MUL: {ALU_OUT_HI,ALU_OUT} = full 2*WIDTH unsigned product. Shifts zero-fill; shift by 0 -> A.
// - RST during DIV: abort, return to IDLE with reset values; no OUT_VALID for aborted op.
// - RST has priority over a simultaneous accept.
// TESTING (WIDTH=16)
// - ADD 14+7 -> ALU_OUT=21, Arith=1, Carry=0, Zero=0, OUT_VALID 1 cycle after accept.
// - ADD 0xFFFF+0x0001 -> ALU_OUT=0, Carry=1, Zero=1; SUB 7-14 -> 0xFFF9, Carry=1.
// - MUL 0x0100*0x0100 -> ALU_OUT=0, ALU_OUT_HI=1; MUL 14*7 -> 98, HI=0.
// - DIV 100/7 -> IN_READY=0 for 16 cycles, OUT_VALID on cycle 17, ALU_OUT=14, HI=2; ops offered meanwhile are dropped.
// - DIV 5/0 -> latency 1, ALU_OUT=0xFFFF, HI=5, DivZero=1; SHL 0x000C by 3 -> 0x0060, Shift=1.
// - RST asserted 5 cycles into DIV -> next cycle IN_READY=1, OUT_VALID=0, outputs 0; following EQ 10,10 -> 1, CMP=1.

Source files
------------

// File: rtl/alu_mc_param.sv
// alu_mc_param: parametrised 16-op ALU with double-width MUL and an iterative restoring divider.
// Latency: 1 cycle for every op except DIV with B!=0, which takes WIDTH+1 cycles.
// Backpressure: IN_READY is low while dividing and offers are dropped then; no output back-pressure.
module alu_mc_param #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic [WIDTH-1:0] ALU_OUT_HI,
   output logic             OUT_VALID,
   output logic             Arith_flag,
   output logic             Logic_flag,
   output logic             CMP_flag,
   output logic             Shift_flag,
   output logic             Carry_flag,
   output logic             Zero_flag,
   output logic             DivZero_flag
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

   state_t             state, state_nxt;
   logic               accept, div_start, div_last;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   quo, dvs, rem;
   logic [WIDTH:0]     rem_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_nx, quo_nx;
   logic [WIDTH:0]     add_full;
   logic [2*WIDTH-1:0] mul_full;
   logic [WIDTH-1:0]   res_lo, res_hi;
   logic               f_arith, f_logic, f_cmp, f_shift, f_carry, f_dz;

   assign accept    = IN_VALID & IN_READY;
   // Division by zero completes in one cycle, so only a non-zero divisor enters the DIV state.
   assign div_start = accept && (ALU_FUN == 4'h3) && (B != '0);
   assign div_last  = (state == S_DIV) && (cnt == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake: ready whenever idle, including the cycle a division result appears.
   always_comb begin
      state_nxt = state;
      IN_READY  = 1'b0;
      case (state)
         S_IDLE: begin
            IN_READY = 1'b1;
            if (div_start) state_nxt = S_DIV;
         end
         S_DIV: begin
            if (div_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Single-cycle function map, evaluated on the live operands.
   always_comb begin
      add_full = {1'b0, A} + {1'b0, B};
      mul_full = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
      res_lo   = '0;
      res_hi   = '0;
      f_arith  = 1'b0;
      f_logic  = 1'b0;
      f_cmp    = 1'b0;
      f_shift  = 1'b0;
      f_carry  = 1'b0;
      f_dz     = 1'b0;
      case (ALU_FUN)
         4'h0: begin res_lo = add_full[WIDTH-1:0]; f_carry = add_full[WIDTH]; f_arith = 1'b1; end
         4'h1: begin res_lo = A - B; f_carry = (A < B); f_arith = 1'b1; end
         4'h2: begin {res_hi, res_lo} = mul_full; f_arith = 1'b1; end
         4'h3: begin
            f_arith = 1'b1;
            if (B == '0) begin
               res_lo = '1;
               res_hi = A;
               f_dz   = 1'b1;
            end
         end
         4'h4: begin res_lo = A & B;    f_logic = 1'b1; end
         4'h5: begin res_lo = A | B;    f_logic = 1'b1; end
         4'h6: begin res_lo = ~(A & B); f_logic = 1'b1; end
         4'h7: begin res_lo = ~(A | B); f_logic = 1'b1; end
         4'h8: begin res_lo = A ^ B;    f_logic = 1'b1; end
         4'h9: begin res_lo = ~(A ^ B); f_logic = 1'b1; end
         4'hA: begin res_lo = (A == B) ? WIDTH'(1) : '0; f_cmp = 1'b1; end
         4'hB: begin res_lo = (A > B)  ? WIDTH'(2) : '0; f_cmp = 1'b1; end
         4'hC: begin res_lo = (A < B)  ? WIDTH'(3) : '0; f_cmp = 1'b1; end
         4'hD: begin res_lo = A >> B[SHW-1:0]; f_shift = 1'b1; end
         4'hE: begin res_lo = A << B[SHW-1:0]; f_shift = 1'b1; end
         default: ;
      endcase
   end

   // One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      div_ge = (rem_sh >= {1'b0, dvs});
      rem_nx = WIDTH'(div_ge ? (rem_sh - {1'b0, dvs}) : rem_sh);
      quo_nx = {quo[WIDTH-2:0], div_ge};
   end

   // Result registers and divider state; results and flags hold between OUT_VALID strobes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID    <= 1'b0;
         ALU_OUT      <= '0;
         ALU_OUT_HI   <= '0;
         Arith_flag   <= 1'b0;
         Logic_flag   <= 1'b0;
         CMP_flag     <= 1'b0;
         Shift_flag   <= 1'b0;
         Carry_flag   <= 1'b0;
         Zero_flag    <= 1'b0;
         DivZero_flag <= 1'b0;
         quo          <= '0;
         dvs          <= '0;
         rem          <= '0;
         cnt          <= '0;
      end else begin
         OUT_VALID <= 1'b0;
         if (accept && !div_start) begin
            OUT_VALID    <= 1'b1;
            ALU_OUT      <= res_lo;
            ALU_OUT_HI   <= res_hi;
            Arith_flag   <= f_arith;
            Logic_flag   <= f_logic;
            CMP_flag     <= f_cmp;
            Shift_flag   <= f_shift;
            Carry_flag   <= f_carry;
            Zero_flag    <= (res_lo == '0);
            DivZero_flag <= f_dz;
         end
         if (div_start) begin
            quo <= A;
            dvs <= B;
            rem <= '0;
            cnt <= '0;
         end
         if (state == S_DIV) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (div_last) begin
               OUT_VALID    <= 1'b1;
               ALU_OUT      <= quo_nx;
               ALU_OUT_HI   <= rem_nx;
               Arith_flag   <= 1'b1;
               Logic_flag   <= 1'b0;
               CMP_flag     <= 1'b0;
               Shift_flag   <= 1'b0;
               Carry_flag   <= 1'b0;
               Zero_flag    <= (quo_nx == '0);
               DivZero_flag <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_mc_param.sv
// tb_alu_mc_param: directed vectors against alu_mc_param (WIDTH=16) with a cycle-level reference model.
// Latency: model predicts OUT_VALID one cycle after accept, or 17 cycles for a real division.
// Backpressure: model drops offers while busy; driver holds an op until it is accepted.
module tb_alu_mc_param;
   localparam int W = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [W-1:0]  A = '0, B = '0;
   logic [3:0]    ALU_FUN = '0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY, OUT_VALID;
   logic [W-1:0]  ALU_OUT, ALU_OUT_HI;
   logic          Arith_flag, Logic_flag, CMP_flag, Shift_flag, Carry_flag, Zero_flag, DivZero_flag;

   int errors = 0;
   int checks = 0;

   alu_mc_param #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .ALU_OUT(ALU_OUT), .ALU_OUT_HI(ALU_OUT_HI), .OUT_VALID(OUT_VALID),
      .Arith_flag(Arith_flag), .Logic_flag(Logic_flag), .CMP_flag(CMP_flag),
      .Shift_flag(Shift_flag), .Carry_flag(Carry_flag), .Zero_flag(Zero_flag),
      .DivZero_flag(DivZero_flag)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [6:0]   fl;   // {arith, logic, cmp, shift, carry, zero, divzero}
   } res_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected result straight from the function table, using plain integer arithmetic.
   function automatic res_t calc(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t   r;
      longint ua, ub, v, h;
      bit     ar, lg, cm, sh, cy, dz;
      ua = a; ub = b; v = 0; h = 0;
      ar = 0; lg = 0; cm = 0; sh = 0; cy = 0; dz = 0;
      case (f)
         4'h0: begin v = ua + ub; cy = (v > 65535); ar = 1; end
         4'h1: begin v = ua - ub; cy = (ua < ub); ar = 1; end
         4'h2: begin v = ua * ub; h = v >> 16; ar = 1; end
         4'h3: begin
            ar = 1;
            if (ub == 0) begin v = 65535; h = ua; dz = 1; end
            else begin v = ua / ub; h = ua % ub; end
         end
         4'h4: begin v = ua & ub;    lg = 1; end
         4'h5: begin v = ua | ub;    lg = 1; end
         4'h6: begin v = ~(ua & ub); lg = 1; end
         4'h7: begin v = ~(ua | ub); lg = 1; end
         4'h8: begin v = ua ^ ub;    lg = 1; end
         4'h9: begin v = ~(ua ^ ub); lg = 1; end
         4'hA: begin v = (ua == ub) ? 1 : 0; cm = 1; end
         4'hB: begin v = (ua > ub)  ? 2 : 0; cm = 1; end
         4'hC: begin v = (ua < ub)  ? 3 : 0; cm = 1; end
         4'hD: begin v = ua >> (ub % 16); sh = 1; end
         4'hE: begin v = ua << (ub % 16); sh = 1; end
         default: v = 0;
      endcase
      r.lo = v[W-1:0];
      r.hi = h[W-1:0];
      r.fl = {ar, lg, cm, sh, cy, (r.lo == 0), dz};
      return r;
   endfunction

   // Reference model: state the DUT must show in the current cycle.
   bit   started = 0;
   bit   m_ready, m_ovalid;
   res_t m_res, m_div;
   int   div_left = 0;

   // Compare the DUT against the model, then advance the model with the inputs seen at the next edge.
   always @(negedge CLK) begin
      if (started) begin
         chk("mdl_in_ready",   IN_READY,   m_ready);
         chk("mdl_out_valid",  OUT_VALID,  m_ovalid);
         chk("mdl_alu_out",    ALU_OUT,    m_res.lo);
         chk("mdl_alu_out_hi", ALU_OUT_HI, m_res.hi);
         chk("mdl_flags", {Arith_flag, Logic_flag, CMP_flag, Shift_flag, Carry_flag, Zero_flag, DivZero_flag}, m_res.fl);
      end
      if (RST) begin
         started  = 1;
         m_ready  = 1;
         m_ovalid = 0;
         m_res.lo = '0;
         m_res.hi = '0;
         m_res.fl = '0;
         div_left = 0;
      end else if (started) begin
         m_ovalid = 0;
         if (div_left > 0) begin
            div_left--;
            if (div_left == 0) begin
               m_res    = m_div;
               m_ovalid = 1;
               m_ready  = 1;
            end
         end else if (IN_VALID && m_ready) begin
            if (ALU_FUN == 4'h3 && B != 0) begin
               m_div    = calc(ALU_FUN, A, B);
               div_left = W;
               m_ready  = 0;
            end else begin
               m_res    = calc(ALU_FUN, A, B);
               m_ovalid = 1;
            end
         end
      end
   end

   // Offer one op and hold it until accepted; returns just after the accepting edge.
   task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      bit acc;
      acc = 0;
      A = a; B = b; ALU_FUN = f; IN_VALID = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         acc = IN_READY;
         @(posedge CLK);
         #1;
         if (acc) break;
      end
      IN_VALID = 1'b0;
      if (!acc) chk("accept_timeout", 1, 0);
   endtask

   // Issue an op and measure the cycles to OUT_VALID and the busy cycles; optional offers while busy.
   task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise, output int lat, output int busy);
      issue(f, a, b);
      if (noise) begin
         A = 16'd1; B = 16'd1; ALU_FUN = 4'h0; IN_VALID = 1'b1;
      end
      lat  = 1;
      busy = 0;
      while (lat < 40) begin
         @(negedge CLK);
         if (OUT_VALID) break;
         if (!IN_READY) busy++;
         @(posedge CLK);
         #1;
         lat++;
         if (lat == 6) IN_VALID = 1'b0;
      end
      @(posedge CLK);
      #1;
   endtask

   typedef struct { logic [3:0] f; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
   vec_t burst[$];

   initial begin
      int lat, busy;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_in_ready",  IN_READY,  1);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_alu_out",   ALU_OUT,   0);
      chk("rst_zero",      Zero_flag, 0);
      @(posedge CLK);
      #1;

      run_op(4'h0, 16'd14, 16'd7, 0, lat, busy);
      chk("add_lat", lat, 1);
      chk("add_out", ALU_OUT, 21);
      chk("add_arith_carry_zero", {Arith_flag, Carry_flag, Zero_flag}, 3'b100);

      run_op(4'h0, 16'hFFFF, 16'h0001, 0, lat, busy);
      chk("add_wrap_out", ALU_OUT, 0);
      chk("add_wrap_carry_zero", {Carry_flag, Zero_flag}, 2'b11);

      run_op(4'h1, 16'd7, 16'd14, 0, lat, busy);
      chk("sub_out", ALU_OUT, 16'hFFF9);
      chk("sub_borrow", Carry_flag, 1);

      run_op(4'h2, 16'h0100, 16'h0100, 0, lat, busy);
      chk("mul_big", {ALU_OUT_HI, ALU_OUT}, 32'h0001_0000);
      run_op(4'h2, 16'd14, 16'd7, 0, lat, busy);
      chk("mul_small", {ALU_OUT_HI, ALU_OUT}, 32'd98);

      run_op(4'h3, 16'd100, 16'd7, 1, lat, busy);
      chk("div_lat", lat, 17);
      chk("div_busy", busy, 16);
      chk("div_quo_rem", {ALU_OUT_HI, ALU_OUT}, {16'd2, 16'd14});

      run_op(4'h3, 16'd5, 16'd0, 0, lat, busy);
      chk("div0_lat", lat, 1);
      chk("div0_out", {ALU_OUT_HI, ALU_OUT}, {16'd5, 16'hFFFF});
      chk("div0_flags", {Arith_flag, DivZero_flag}, 2'b11);

      run_op(4'hE, 16'h000C, 16'd3, 0, lat, busy);
      chk("shl_out", ALU_OUT, 16'h0060);
      chk("shl_flag", Shift_flag, 1);

      // Op held through a division, accepted in the cycle the quotient appears.
      issue(4'h3, 16'd1000, 16'd3);
      issue(4'h0, 16'd2, 16'd3);
      @(negedge CLK);
      chk("held_add_out", ALU_OUT, 5);
      @(posedge CLK);
      #1;

      // Back-to-back burst covering the remaining function codes.
      burst = '{'{4'h4, 16'hF0F0, 16'hFF00}, '{4'h5, 16'hF0F0, 16'h0F0F}, '{4'h6, 16'hFFFF, 16'hFFFF},
                '{4'h7, 16'h0000, 16'h0000}, '{4'h8, 16'hAAAA, 16'h5555}, '{4'h9, 16'h1234, 16'h1234},
                '{4'hB, 16'd5, 16'd3}, '{4'hC, 16'd3, 16'd5}, '{4'hD, 16'h8000, 16'h0013},
                '{4'hD, 16'hABCD, 16'h0010}, '{4'hE, 16'h0001, 16'h000F}, '{4'hF, 16'd7, 16'd7},
                '{4'hA, 16'd1, 16'd2}, '{4'hB, 16'd3, 16'd5}};
      foreach (burst[i]) issue(burst[i].f, burst[i].a, burst[i].b);
      repeat (3) @(posedge CLK);
      #1;

      // Reset five cycles into a division aborts it.
      issue(4'h3, 16'd100, 16'd7);
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("abort_in_ready",  IN_READY,  1);
      chk("abort_out_valid", OUT_VALID, 0);
      chk("abort_outs", {ALU_OUT_HI, ALU_OUT}, 0);
      @(posedge CLK);
      #1;
      run_op(4'hA, 16'd10, 16'd10, 0, lat, busy);
      chk("eq_lat", lat, 1);
      chk("eq_out", ALU_OUT, 1);
      chk("eq_cmp", CMP_flag, 1);
      repeat (20) @(posedge CLK);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
